uc_rr_arbiter: RTL

// - Parametrised unit-clause (UC) arbiter between clause memory and NUM_ENGINE BCP engines.
// - Loads initial UCs from memory, then round-robin arbitrates learned UCs from the engines.
// - Tracks per-variable assignment, detects conflicts (x and -x both seen), broadcasts accepted UCs

---
 rtl/uc_rr_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uc_rr_arbiter.sv
// rtl/uc_rr_arbiter.sv - unit-clause arbiter: memory load, round-robin engine grants, conflict detect, broadcast FIFO
// Optional build macro UCA_DEDUP_EN: drop same-sign duplicate literals instead of broadcasting them again.
module uc_rr_arbiter #(
    parameter int NUM_ENGINE = 4,
    parameter int LIT_W      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem2uca_valid,
    input  logic [LIT_W-1:0]            mem2uca,
    input  logic                        mem2uca_done,
    output logic                        mem2uca_ready,
    input  logic [NUM_ENGINE-1:0]       eng2uca_valid,
    input  logic [NUM_ENGINE*LIT_W-1:0] eng2uca,
    output logic [NUM_ENGINE-1:0]       engmask,
    output logic                        uca2eng_valid,
    output logic [LIT_W-1:0]            uca2eng,
    input  logic                        eng2uca_rd,
    output logic                        conflict
);

    localparam int NUM_VAR = 2 ** (LIT_W - 1);
    localparam int PTR_W   = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW      = AW + 1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_CONFLICT
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_VAR-1:0]     assigned_q, assigned_d;
    logic [NUM_VAR-1:0]     neg_q, neg_d;
    logic [LIT_W-1:0]       fifo_q [FIFO_DEPTH];
    logic [LIT_W-1:0]       fifo_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   conflict_q, conflict_d;

    logic                   full;
    logic                   grant_found;
    logic [PTR_W-1:0]       grant_idx;
    int                     scan_idx;
    logic                   accept;
    logic [LIT_W-1:0]       acc_lit;
    logic [LIT_W-1:0]       mag;
    logic [LIT_W-2:0]       var_idx;
    logic                   lit_neg;
    logic                   ignore;
    logic                   push;
    logic                   pop;

    // Ready depends only on the registered count, so a same-cycle pop never opens a slot.
    assign full          = (count_q == CW'(FIFO_DEPTH));
    assign mem2uca_ready = (state_q == ST_LOAD) && !full;
    assign uca2eng_valid = (count_q != '0);
    assign uca2eng       = uca2eng_valid ? fifo_q[rd_ptr_q] : '0;
    assign conflict      = conflict_q;
    assign pop           = eng2uca_rd && uca2eng_valid;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        engmask     = '0;
        if (state_q == ST_RUN && !full) begin
            for (int i = 0; i < NUM_ENGINE; i++) begin
                scan_idx = (int'(rr_ptr_q) + i) % NUM_ENGINE;
                if (!grant_found && eng2uca_valid[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = PTR_W'(scan_idx);
                end
            end
        end
        if (grant_found) begin
            engmask[grant_idx] = 1'b1;
        end
    end

    // Magnitude MSB is set only for the most negative literal, which has no variable.
    assign accept  = grant_found || (mem2uca_valid && mem2uca_ready);
    assign acc_lit = grant_found ? eng2uca[int'(grant_idx)*LIT_W +: LIT_W] : mem2uca;
    assign lit_neg = acc_lit[LIT_W-1];
    assign mag     = lit_neg ? -acc_lit : acc_lit;
    assign var_idx = mag[LIT_W-2:0];
    assign ignore  = (acc_lit == '0) || mag[LIT_W-1];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        assigned_d = assigned_q;
        neg_d      = neg_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        conflict_d = conflict_q;
        push       = 1'b0;

        if (state_q == ST_LOAD && mem2uca_done) begin
            state_d = ST_RUN;
        end
        if (grant_found) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_ENGINE - 1)) ? '0 : grant_idx + 1'b1;
        end

        if (accept && !ignore) begin
            if (!assigned_q[var_idx]) begin
                assigned_d[var_idx] = 1'b1;
                neg_d[var_idx]      = lit_neg;
                push                = 1'b1;
            end else if (neg_q[var_idx] != lit_neg) begin
                conflict_d = 1'b1;
                state_d    = ST_CONFLICT;
            end else begin
`ifdef UCA_DEDUP_EN
                push = 1'b0;
`else
                push = 1'b1;
`endif
            end
        end

        if (push) begin
            fifo_d[wr_ptr_q] = acc_lit;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (state_d == ST_CONFLICT) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            rr_ptr_q   <= '0;
            assigned_q <= '0;
            neg_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            assigned_q <= assigned_d;
            neg_q      <= neg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            conflict_q <= conflict_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule
